// File: rtl/vga_scan_driver_pkg.sv
// Shared definitions for the VGA scan driver and the pixel sources it polls
// (game field, score overlay, borders): color/coordinate types, the standard
// 640x480@60 timing and the common background/border colors.
package vga_scan_driver_pkg;

  localparam int COLOR_W     = 8;
  localparam int COORD_W     = 10;
  localparam int FRAME_CNT_W = 8;

  typedef logic [COLOR_W-1:0] color_t;   // RRRGGGBB
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   pos_t;     // one spare bit so window ends of 1024 fit

  localparam color_t BG_COLOR         = 8'h00;
  localparam color_t BORDER_COLOR_DEF = 8'b000_000_01;

  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_VIS  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  // Half-open window test lo <= pos < hi.
  function automatic logic in_window(input pos_t pos, input pos_t lo, input pos_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_scan_driver_if.sv
// Pixel-source bus: the scan driver publishes the coordinate being evaluated,
// the source answers with a color and a flag saying whether it owns the pixel.
interface vga_scan_driver_if;
  import vga_scan_driver_pkg::*;

  coord_t eval_x;
  coord_t eval_y;
  color_t color_in;
  logic   color_valid_in;

  modport master (output eval_x, output eval_y, input color_in, input color_valid_in);
  modport slave  (input eval_x, input eval_y, output color_in, output color_valid_in);

endinterface

// File: rtl/vga_scan_driver_scan_counter.sv
// Modulo-N counter with enable and synchronous reset. wrap_o is high on the
// enabled clk where the count rolls from N-1 back to 0.
module vga_scan_driver_scan_counter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q, count_d;

  assign wrap_o  = en_i && (count_q == W'(N - 1));
  assign count_o = count_q;

  // Next count: hold, increment, or roll over to zero.
  always_comb begin
    count_d = count_q;
    if (en_i) count_d = wrap_o ? '0 : count_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/vga_scan_driver.sv
// Raster-scan initiator: walks eval_x/eval_y over the full VGA timing, samples
// the source color on the last clk of each pixel, and registers rgb/hsync/vsync
// together so they stay mutually aligned. Also produces frame_start and the
// frame-derived game_tick.
module vga_scan_driver
  import vga_scan_driver_pkg::*;
#(
  parameter int     CLK_DIV      = 2,
  parameter int     H_VIS        = VGA_H_VIS,
  parameter int     H_FP         = VGA_H_FP,
  parameter int     H_SYNC       = VGA_H_SYNC,
  parameter int     H_BP         = VGA_H_BP,
  parameter int     V_VIS        = VGA_V_VIS,
  parameter int     V_FP         = VGA_V_FP,
  parameter int     V_SYNC       = VGA_V_SYNC,
  parameter int     V_BP         = VGA_V_BP,
  parameter bit     SYNC_POL     = 1'b0,
  parameter int     TICK_FRAMES  = 6,
  parameter color_t BORDER_COLOR = BORDER_COLOR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  vga_scan_driver_if.master src,
  output logic              hsync,
  output logic              vsync,
  output color_t            rgb,
  output logic              frame_start,
  output logic              game_tick
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_scan_driver: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_scan_driver: CLK_DIV must be at least 2");
  end
  if (TICK_FRAMES < 1 || TICK_FRAMES > 255) begin : g_bad_tick
    $error("vga_scan_driver: TICK_FRAMES must be in 1..255");
  end

  localparam pos_t H_VIS_P = pos_t'(H_VIS);
  localparam pos_t V_VIS_P = pos_t'(V_VIS);
  localparam pos_t HS_LO   = pos_t'(H_VIS + H_FP);
  localparam pos_t HS_HI   = pos_t'(H_VIS + H_FP + H_SYNC);
  localparam pos_t VS_LO   = pos_t'(V_VIS + V_FP);
  localparam pos_t VS_HI   = pos_t'(V_VIS + V_FP + V_SYNC);

  logic                   pix_en, h_wrap, v_wrap, frm_wrap;
  logic [DIV_W-1:0]       div_cnt;
  coord_t                 h_cnt, v_cnt;
  logic [FRAME_CNT_W-1:0] frm_cnt;
  logic                   unused_cnt;

  assign unused_cnt = ^{div_cnt, frm_cnt};

  vga_scan_driver_scan_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
    .clk(clk), .reset(reset), .en_i(1'b1), .count_o(div_cnt), .wrap_o(pix_en));

  vga_scan_driver_scan_counter #(.N(H_TOTAL), .W(COORD_W)) u_h (
    .clk(clk), .reset(reset), .en_i(pix_en), .count_o(h_cnt), .wrap_o(h_wrap));

  vga_scan_driver_scan_counter #(.N(V_TOTAL), .W(COORD_W)) u_v (
    .clk(clk), .reset(reset), .en_i(h_wrap), .count_o(v_cnt), .wrap_o(v_wrap));

  // Frames only count while running, so a pause stretches the tick period.
  vga_scan_driver_scan_counter #(.N(TICK_FRAMES), .W(FRAME_CNT_W)) u_frm (
    .clk(clk), .reset(reset), .en_i(v_wrap && run), .count_o(frm_cnt), .wrap_o(frm_wrap));

  assign src.eval_x = h_cnt;
  assign src.eval_y = v_cnt;

  function automatic logic sync_level(input logic active);
    return active ? SYNC_POL : ~SYNC_POL;
  endfunction

  logic   visible;
  color_t rgb_d, rgb_q;
  logic   hsync_d, hsync_q, vsync_d, vsync_q;
  logic   frame_start_q, game_tick_q;

  // Decode the pixel ending this clk into its DAC color and sync levels.
  always_comb begin
    visible = in_window({1'b0, h_cnt}, '0, H_VIS_P) && in_window({1'b0, v_cnt}, '0, V_VIS_P);
    rgb_d   = BG_COLOR;
    if (visible) rgb_d = src.color_valid_in ? src.color_in : BORDER_COLOR;
    hsync_d = sync_level(in_window({1'b0, h_cnt}, HS_LO, HS_HI));
    vsync_d = sync_level(in_window({1'b0, v_cnt}, VS_LO, VS_HI));
  end

  // Output stage: pixel data updates once per pixel, pulses mark the 0,0 wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q         <= BG_COLOR;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
      game_tick_q   <= 1'b0;
    end else begin
      if (pix_en) begin
        rgb_q   <= rgb_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
      end
      frame_start_q <= v_wrap;
      game_tick_q   <= frm_wrap;
    end
  end

  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign game_tick   = game_tick_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver on a shrunken raster (24x13 pixels) so many frames
// fit in a short run. A pixel source answers one clk after eval changes; a
// position-based reference model predicts every output on every clk.
module tb_vga_scan_driver;
  import vga_scan_driver_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int H_VIS = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_VIS = 8,  V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int TICK  = 6;
  localparam int HT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FCLK  = HT * VT * CLK_DIV;
  localparam logic [7:0] BORDER = 8'b000_000_01;
  localparam int NPROBE = 7;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] color;
    logic       valid;
    logic [7:0] exp_rgb;
  } probe_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   run = 1'b1;
  logic   hsync, vsync, frame_start, game_tick;
  color_t rgb;
  int     total = 0;
  int     bad = 0;
  int unsigned seed = 0;
  probe_t probes [NPROBE];

  vga_scan_driver_if pix ();

  vga_scan_driver #(
    .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(1'b0), .TICK_FRAMES(TICK), .BORDER_COLOR(BORDER)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .src(pix),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .frame_start(frame_start), .game_tick(game_tick)
  );

  always #5 clk = ~clk;

  // Source answer for a coordinate: probe overrides, else a seeded hash.
  function automatic logic [8:0] src_val(input int x, input int y);
    int unsigned t;
    for (int i = 0; i < NPROBE; i++)
      if (probes[i].x == x && probes[i].y == y) return {probes[i].valid, probes[i].color};
    t = seed + 32'(x) * 37 + 32'(y) * 1013;
    return {(t[5:4] != 2'b00), t[15:8] ^ t[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic wait_eval(input int x, input int y, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (int'(pix.eval_x) == x && int'(pix.eval_y) == y) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic count_until_tick(input int bound, output int edges);
    edges = 0;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk); #1;
      if (game_tick) begin
        edges = i;
        break;
      end
    end
  endtask

  // Pixel source: answers one clk after eval changes.
  initial begin : source
    forever begin
      @(posedge clk); #1;
      {pix.color_valid_in, pix.color_in} = src_val(int'(pix.eval_x), int'(pix.eval_y));
    end
  end

  // Reference model: everything follows from the clk count n since reset.
  initial begin : scoreboard
    int n, fc, p, q, ex, ey, ox, oy;
    bit seen;
    logic rs, rn, efs, egt, ehs, evs;
    logic [7:0] erg;
    logic [8:0] sv;
    logic [31:0] act, expv;
    n = 0; fc = 0; seen = 1'b0; efs = 1'b0; egt = 1'b0;
    forever begin
      @(posedge clk);
      rs = reset;
      rn = run;
      #1;
      if (rs) begin
        n = 0; fc = 0; seen = 1'b1; efs = 1'b0; egt = 1'b0;
      end else if (seen) begin
        n++;
        efs = (n % FCLK == 0);
        egt = 1'b0;
        if (efs && rn) begin
          if (fc == TICK - 1) begin
            fc = 0;
            egt = 1'b1;
          end else fc++;
        end
      end
      if (seen) begin
        p  = n / CLK_DIV;
        ex = p % HT;
        ey = (p / HT) % VT;
        if (p == 0) begin
          erg = 8'h00; ehs = 1'b1; evs = 1'b1;
        end else begin
          q  = p - 1;
          ox = q % HT;
          oy = (q / HT) % VT;
          sv = src_val(ox, oy);
          erg = (ox < H_VIS && oy < V_VIS) ? (sv[8] ? sv[7:0] : BORDER) : 8'h00;
          ehs = !(ox >= H_VIS + H_FP && ox < H_VIS + H_FP + H_SYNC);
          evs = !(oy >= V_VIS + V_FP && oy < V_VIS + V_FP + V_SYNC);
        end
        expv = {10'(ex), 10'(ey), ehs, evs, erg, efs, egt};
        act  = {pix.eval_x, pix.eval_y, hsync, vsync, rgb, frame_start, game_tick};
        total++;
        if (act !== expv) begin
          bad++;
          $display("FAIL scan n=%0d got=%h want=%h", n, act, expv);
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int first, low, at, edges, fsn, fs3;
    bit ok;
    seed = $urandom;
    probes[0] = '{20, 3, 8'hFF, 1'b1, 8'h00};   // horizontal blanking ignores source
    probes[1] = '{10, 5, 8'hE3, 1'b1, 8'hE3};   // ordinary visible pixel
    probes[2] = '{0,  7, 8'h9A, 1'b0, BORDER};  // no owner -> border color
    probes[3] = '{15, 7, 8'h3C, 1'b1, 8'h3C};   // last visible pixel
    probes[4] = '{16, 7, 8'hAA, 1'b1, 8'h00};   // first front-porch pixel
    probes[5] = '{5,  8, 8'h77, 1'b1, 8'h00};   // first blank line
    probes[6] = '{0,  0, 8'h55, 1'b0, BORDER};  // origin, no owner

    // Reset held 5 clks
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_state", {pix.eval_x, pix.eval_y, hsync, vsync, rgb, frame_start, game_tick},
        {20'd0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0});
    reset = 1'b0;
    @(posedge clk); #1;
    chk("h_after_1clk", 32'(pix.eval_x), 32'd0);
    @(posedge clk); #1;
    chk("h_after_2clk", 32'(pix.eval_x), 32'd1);

    // Probe table: rgb one clk after eval leaves the probed pixel
    for (int i = 0; i < NPROBE; i++) begin
      wait_eval(probes[i].x, probes[i].y, 2 * FCLK, ok);
      chk("probe_reached", 32'(ok), 32'd1);
      for (int k = 0; k < 8; k++) begin
        if (!(int'(pix.eval_x) == probes[i].x && int'(pix.eval_y) == probes[i].y)) break;
        @(negedge clk);
      end
      @(posedge clk); #1;
      chk($sformatf("probe_rgb_%0d_%0d", probes[i].x, probes[i].y), 32'(rgb), 32'(probes[i].exp_rgb));
    end

    // Hsync pulse over one visible line
    wait_eval(0, 2, 2 * FCLK, ok);
    chk("line_reached", 32'(ok), 32'd1);
    low = 0; first = -1;
    for (int i = 0; i < HT * CLK_DIV; i++) begin
      @(posedge clk); #1;
      if (!hsync) begin
        if (low == 0) first = int'(pix.eval_x);
        low++;
      end
    end
    chk("hsync_low_clks", 32'(low), 32'(H_SYNC * CLK_DIV));
    // sync for pixel h shows while eval already points at h+1
    chk("hsync_start", 32'(first), 32'(H_VIS + H_FP + 1));

    // Vsync pulse and frame length
    count_until_tick(0, edges);
    at = 0;
    for (int i = 1; i <= 2 * FCLK; i++) begin
      @(posedge clk); #1;
      if (frame_start) begin
        at = i;
        break;
      end
    end
    chk("frame_start_seen", 32'(at != 0), 32'd1);
    low = 0; first = -1; at = 0;
    for (int i = 1; i <= FCLK; i++) begin
      @(posedge clk); #1;
      if (!vsync) begin
        if (low == 0) first = int'(pix.eval_y);
        low++;
      end
      if (frame_start && at == 0) at = i;
    end
    chk("vsync_low_clks", 32'(low), 32'(V_SYNC * HT * CLK_DIV));
    chk("vsync_first_line", 32'(first), 32'(V_VIS + V_FP));
    chk("frame_length", 32'(at), 32'(FCLK));

    // game_tick period with run held high
    count_until_tick(7 * FCLK, edges);
    chk("tick_seen", 32'(edges != 0), 32'd1);
    chk("tick_with_frame_start", 32'(frame_start), 32'd1);
    @(posedge clk); #1;
    chk("tick_width", 32'(game_tick), 32'd0);
    count_until_tick(7 * FCLK, edges);
    chk("tick_period", 32'(edges + 1), 32'(TICK * FCLK));

    // Pause across three frame boundaries stretches the period by three frames
    fsn = 0; fs3 = -1; edges = 0;
    for (int i = 1; i <= 12 * FCLK; i++) begin
      @(posedge clk); #1;
      if (game_tick) begin
        edges = i;
        break;
      end
      if (frame_start) begin
        fsn++;
        if (fsn == 3) fs3 = i;
      end
      if (i == 300) run = 1'b0;
      if (fs3 > 0 && i == fs3 + 300) run = 1'b1;
    end
    chk("tick_period_paused", 32'(edges), 32'((TICK + 3) * FCLK));

    // Random run toggling with one random reset, checked by the model
    for (int r = 0; r < 16; r++) begin
      repeat ($urandom_range(40, 900)) @(negedge clk);
      run = 1'($urandom % 2);
      if (r == 8) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b0;
      end
    end
    @(negedge clk);
    run = 1'b1;

    // Reset in mid-frame
    wait_eval(12, 5, 2 * FCLK, ok);
    chk("midframe_reached", 32'(ok), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_eval", {12'd0, pix.eval_x, pix.eval_y}, 32'd0);
    chk("midreset_pulses", 32'({frame_start, game_tick}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    count_until_tick(7 * FCLK, edges);
    chk("tick_after_reset", 32'(edges), 32'(TICK * FCLK));

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
